// File: rtl/ber_counter.sv
// ber_counter: BER checker for the PRBS9/BPSK link.
// Samples the RC-filter sign once per symbol at a selectable phase, searches for
// the channel delay against the transmitted PRBS9 stream, then counts errors and bits.
module ber_counter #(
    parameter int OS     = 4,
    parameter int DLY_W  = 9,
    parameter int WINDOW = 511,
    parameter int CNT_W  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_enable,
    input  logic                    i_rx_sample,
    input  logic                    i_tx_bit,
    input  logic [$clog2(OS)-1:0]   i_offset,
    output logic                    o_locked,
    output logic [DLY_W-1:0]        o_delay,
    output logic [CNT_W-1:0]        o_err_cnt,
    output logic [CNT_W-1:0]        o_bit_cnt,
    output logic                    o_is_zero
);

    localparam int PH_W  = $clog2(OS);
    localparam int REF_N = 2 ** DLY_W;
    localparam int WIN_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [REF_N-1:0]     ref_q, ref_d;
    logic [DLY_W-1:0]     delay_q, delay_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic [CNT_W-1:0]     bit_q, bit_d;

    logic shift;
    logic capture;
    logic rx_bit;
    logic mismatch;

    // Capture/shift strobes and the per-symbol compare against the reference line.
    always_comb begin
        shift    = i_enable && (phase_q == '0);
        capture  = i_enable && (phase_q == i_offset);
        rx_bit   = ~i_rx_sample;
        // On an offset-0 capture this reads ref_q before the shift lands.
        mismatch = rx_bit ^ ref_q[delay_q];
    end

    // Next-state logic for phase, reference line, search FSM and counters.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        phase_d = phase_q;
        ref_d   = ref_q;
        delay_d = delay_q;
        win_d   = win_q;
        err_d   = err_q;
        bit_d   = bit_q;

        if (i_enable) begin
            phase_d = (phase_q == PH_W'(OS - 1)) ? '0 : phase_q + 1'b1;
        end

        if (shift) begin
            ref_d = {ref_q[REF_N-2:0], i_tx_bit};
        end

        unique case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = SEARCH;
                    delay_d = '0;
                    win_d   = '0;
                end
            end
            SEARCH: begin
                if (capture) begin
                    if (mismatch) begin
                        // Natural DLY_W-bit overflow gives the 2^DLY_W-1 -> 0 wrap.
                        delay_d = delay_q + 1'b1;
                        win_d   = '0;
                    end else if (win_q == WIN_W'(WINDOW - 1)) begin
                        state_d = LOCKED;
                        win_d   = '0;
                        err_d   = '0;
                        bit_d   = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (capture) begin
                    if (bit_q != '1) begin
                        bit_d = bit_q + 1'b1;
                    end
                    if (mismatch && (err_q != '1)) begin
                        err_d = err_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous, active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            // NOTE: the reference line is a plain shift register, not RAM, so it is
            // reset like any flop; a stale line would fake matches after reset.
            ref_q   <= '0;
            delay_q <= '0;
            win_q   <= '0;
            err_q   <= '0;
            bit_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            phase_q <= phase_d;
            ref_q   <= ref_d;
            delay_q <= delay_d;
            win_q   <= win_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
        end
    end

    assign o_locked  = (state_q == LOCKED);
    assign o_delay   = delay_q;
    assign o_err_cnt = err_q;
    assign o_bit_cnt = bit_q;
    assign o_is_zero = (state_q == LOCKED) && (err_q == '0);

endmodule
